// File: rtl/aes_key_schedule_rev.sv
// AES-128 decryption key scheduler: iterates the forward expansion to round 10, then
// walks the schedule backwards, emitting round keys 10..0 over a valid/ready port.

module aes_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_inv;
    logic [7:0] w_pow;

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128 (maps 0 to 0).
    always_comb begin
        w_inv = 8'h01;
        w_pow = i_in;
        for (int i = 1; i < 8; i++) begin
            w_pow = gf_mul(w_pow, w_pow);
            w_inv = gf_mul(w_inv, w_pow);
        end
        o_out = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end

endmodule

module aes_key_schedule_rev (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    input  logic [127:0] i_key,
    output logic         o_rk_valid,
    input  logic         i_rk_ready,
    output logic [127:0] o_rk,
    output logic [3:0]   o_rk_round,
    output logic         o_rk_last,
    output logic         o_busy
);

    typedef enum logic [1:0] {StIdle, StExpand, StEmit} state_e;

    state_e      r_state, w_state_nxt;
    logic [31:0] r_a, r_b, r_c, r_d;
    logic [31:0] w_a_nxt, w_b_nxt, w_c_nxt, w_d_nxt;
    logic [3:0]  r_round, w_round_nxt;

    logic        w_emit;
    logic [31:0] w_g_in, w_rot, w_sub, w_g;
    logic [3:0]  w_rcon_idx;
    logic [7:0]  w_rcon;

    assign w_emit = (r_state == StEmit);

    // Shared g(): forward uses d with Rcon[r+1]; reverse uses recovered p3 = d^c with Rcon[r].
    assign w_g_in     = w_emit ? (r_d ^ r_c) : r_d;
    assign w_rcon_idx = w_emit ? r_round : (r_round + 4'd1);
    assign w_rot      = {w_g_in[23:0], w_g_in[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .i_in  (w_rot[8*gi +: 8]),
            .o_out (w_sub[8*gi +: 8])
        );
    end

    always_comb begin
        w_rcon = 8'h00;
        case (w_rcon_idx)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_g = w_sub ^ {w_rcon, 24'h000000};

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_round_nxt = r_round;
        unique case (r_state)
            StIdle: begin
                if (i_key_valid) begin
                    w_a_nxt     = i_key[127:96];
                    w_b_nxt     = i_key[95:64];
                    w_c_nxt     = i_key[63:32];
                    w_d_nxt     = i_key[31:0];
                    w_round_nxt = 4'd0;
                    w_state_nxt = StExpand;
                end
            end
            StExpand: begin
                w_a_nxt     = r_a ^ w_g;
                w_b_nxt     = w_a_nxt ^ r_b;
                w_c_nxt     = w_b_nxt ^ r_c;
                w_d_nxt     = w_c_nxt ^ r_d;
                w_round_nxt = r_round + 4'd1;
                if (r_round == 4'd9) w_state_nxt = StEmit;
            end
            StEmit: begin
                if (i_rk_ready) begin
                    if (r_round == 4'd0) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_d_nxt     = r_d ^ r_c;
                        w_c_nxt     = r_c ^ r_b;
                        w_b_nxt     = r_b ^ r_a;
                        w_a_nxt     = r_a ^ w_g;
                        w_round_nxt = r_round - 4'd1;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= 32'h0;
            r_b     <= 32'h0;
            r_c     <= 32'h0;
            r_d     <= 32'h0;
            r_round <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_round <= w_round_nxt;
        end
    end

    assign o_key_ready = (r_state == StIdle);
    assign o_busy      = (r_state != StIdle);
    assign o_rk_valid  = w_emit;
    assign o_rk        = w_emit ? {r_a, r_b, r_c, r_d} : 128'h0;
    assign o_rk_round  = w_emit ? r_round : 4'd0;
    assign o_rk_last   = w_emit && (r_round == 4'd0);

endmodule

// File: tb/tb_aes_key_schedule_rev.sv
// Randomised bench for aes_key_schedule_rev against a word-array FIPS-197 expansion model.

module tb_aes_key_schedule_rev;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key = 128'h0;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;

    aes_key_schedule_rev u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_key_valid (key_valid),
        .o_key_ready (key_ready),
        .i_key       (key),
        .o_rk_valid  (rk_valid),
        .i_rk_ready  (rk_ready),
        .o_rk        (rk),
        .o_rk_round  (rk_round),
        .o_rk_last   (rk_last),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [2047:0] sbox_flat = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_flat[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    logic [127:0] model [11];
    logic [127:0] got   [11];

    // Standard 44-word expansion; model[r] is round key r.
    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_noise(input bit noise);
        if (noise) begin
            key_valid = 1'($urandom_range(1));
            key       = rand128();
        end
    endtask

    // Offers key k and consumes its schedule; abort_round >= 0 pulses reset while that round is shown.
    task automatic run_key(input logic [127:0] k, input int stall_pct, input bit noise,
                           input bit b2b, input logic [127:0] next_k, input int abort_round);
        int lat;
        int idx;
        int guard;
        int exp_r;
        build_model(k);
        key       = k;
        key_valid = 1'b1;
        check_eq("key_ready_at_offer", key_ready, 1'b1);
        guard = 0;
        while (!key_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        key_valid = 1'b0;
        drive_noise(noise);
        check_eq("busy_after_accept", busy, 1'b1);
        check_eq("key_ready_low_busy", key_ready, 1'b0);
        lat = 0;
        while (!rk_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            drive_noise(noise);
        end
        check_eq("expand_latency", 128'(lat), 128'd10);
        idx   = 0;
        guard = 0;
        while (idx < 11 && guard < 300) begin
            exp_r = 10 - idx;
            if (exp_r == abort_round) begin
                key_valid = 1'b0;
                rst_n     = 1'b0;
                #2;
                check_eq("rst_rk_valid", rk_valid, 1'b0);
                check_eq("rst_rk", rk, 128'h0);
                check_eq("rst_rk_round", 128'(rk_round), 128'd0);
                check_eq("rst_rk_last", rk_last, 1'b0);
                check_eq("rst_key_ready", key_ready, 1'b1);
                check_eq("rst_busy", busy, 1'b0);
                #2;
                rst_n    = 1'b1;
                rk_ready = 1'b0;
                return;
            end
            check_eq("rk_valid", rk_valid, 1'b1);
            check_eq("rk_value", rk, model[exp_r]);
            check_eq("rk_round", 128'(rk_round), 128'(exp_r));
            check_eq("rk_last", rk_last, exp_r == 0);
            got[idx] = rk;
            rk_ready = ($urandom_range(99) >= stall_pct);
            if (exp_r == 0) begin
                key_valid = b2b;
                if (b2b) key = next_k;
            end else begin
                drive_noise(noise);
            end
            @(posedge clk); #1;
            if (rk_ready) idx++;
            guard++;
        end
        if (idx < 11) check_eq("emit_timeout", 128'(idx), 128'd11);
        rk_ready = 1'b0;
        check_eq("key_ready_after_last", key_ready, 1'b1);
        check_eq("rk_valid_after_last", rk_valid, 1'b0);
        check_eq("busy_after_last", busy, 1'b0);
        check_eq("rk_last_after_last", rk_last, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k1;
        logic [127:0] k2;
        #12;
        check_eq("reset_key_ready", key_ready, 1'b1);
        check_eq("reset_rk_valid", rk_valid, 1'b0);
        check_eq("reset_rk", rk, 128'h0);
        check_eq("reset_rk_round", 128'(rk_round), 128'd0);
        check_eq("reset_rk_last", rk_last, 1'b0);
        check_eq("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 1'b0, 1'b0, 128'h0, -1);
        check_eq("fips_round10", got[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_eq("fips_round9", got[1], 128'hac7766f319fadc2128d12941575c006e);
        check_eq("fips_round1", got[9], 128'ha0fafe1788542cb123a339392a6c7605);
        check_eq("fips_round0", got[10], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        run_key(128'h0, 0, 1'b0, 1'b0, 128'h0, -1);
        check_eq("zero_round10", got[0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check_eq("zero_round0", got[10], 128'h0);

        for (int i = 0; i < 4; i++) run_key(rand128(), 40, 1'b1, 1'b0, 128'h0, -1);

        run_key(rand128(), 30, 1'b1, 1'b0, 128'h0, 6);
        run_key(rand128(), 20, 1'b0, 1'b0, 128'h0, -1);

        k1 = rand128();
        k2 = rand128();
        run_key(k1, 0, 1'b0, 1'b1, k2, -1);
        run_key(k2, 25, 1'b1, 1'b0, 128'h0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
